// File: rtl/lkp_req_scheduler.sv
// Round-robin sharing of the module-A lookup port among bank_num banks; IDs tagged {local_id, bank}.
// Latency: 1 cycle request (registered stage), 1 cycle response demux; stage holds until a2c_lkp_rdy.
// Build option LKP_SCHED_CREDIT_EN: per-bank outstanding-lookup credits and underflow error flag.
module lkp_req_scheduler #(
  parameter int bank_num      = 2,
  parameter int info_length   = 20,
  parameter int result_length = 20,
  parameter int req_width     = 10,
  parameter int credit_max    = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [bank_num-1:0]                  bank_req_vld,
  input  logic [bank_num*info_length-1:0]      bank_req_info,
  input  logic [bank_num*(req_width-$clog2(bank_num))-1:0] bank_req_id,
  output logic [bank_num-1:0]                  bank_req_rdy,
  output logic                                 c2a_lkp_vld,
  output logic [info_length-1:0]               c2a_lkp_info,
  output logic [req_width-1:0]                 c2a_lkp_req_id,
  input  logic                                 a2c_lkp_rdy,
  input  logic                                 a2c_lkp_rsp_vld,
  input  logic [req_width-1:0]                 a2c_lkp_rsp_id,
  input  logic [result_length-1:0]             a2c_lkp_rslt,
  output logic [bank_num-1:0]                  bank_rsp_vld,
  output logic [req_width-$clog2(bank_num)-1:0] bank_rsp_id,
  output logic [result_length-1:0]             bank_rsp_rslt,
  output logic                                 lkp_rsp_err
);

  localparam int bw    = $clog2(bank_num);
  localparam int lid_w = req_width - bw;

  logic [bw-1:0]       ptr;
  logic [bank_num-1:0] elig;
  logic [bank_num-1:0] gnt_vec;
  logic [bank_num-1:0] rsp_vec;
  logic [bw-1:0]       gnt_idx;
  logic [bw-1:0]       idx;
  logic                gnt_found;
  logic                stage_free;
  logic                gnt;
  logic [bw-1:0]       rsp_bank;

  assign stage_free = !c2a_lkp_vld || a2c_lkp_rdy;
  assign rsp_bank   = a2c_lkp_rsp_id[bw-1:0];

`ifdef LKP_SCHED_CREDIT_EN
  localparam int cw = $clog2(credit_max + 1);

  logic [cw-1:0] cnt [bank_num];
  logic          err_q;

  always_comb begin
    elig = '0;
    for (int i = 0; i < bank_num; i++)
      elig[i] = bank_req_vld[i] && (cnt[i] < cw'(credit_max));
  end

  // Grant and response on the same bank cancel; a response with no credit out is an underflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < bank_num; i++) cnt[i] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < bank_num; i++) begin
        if (gnt_vec[i] && !rsp_vec[i]) begin
          cnt[i] <= cnt[i] + cw'(1);
        end else if (rsp_vec[i] && !gnt_vec[i]) begin
          if (cnt[i] == '0) err_q <= 1'b1;
          else              cnt[i] <= cnt[i] - cw'(1);
        end
      end
    end
  end

  assign lkp_rsp_err = err_q;
`else
  assign elig        = bank_req_vld;
  assign lkp_rsp_err = 1'b0;
`endif

  // First eligible bank at or after ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = 0; k < bank_num; k++) begin
      idx = ptr + k[bw-1:0];
      if (!gnt_found && elig[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  assign gnt = stage_free && gnt_found;

  always_comb begin
    gnt_vec = '0;
    if (gnt) gnt_vec[gnt_idx] = 1'b1;
  end

  always_comb begin
    rsp_vec = '0;
    if (a2c_lkp_rsp_vld) rsp_vec[rsp_bank] = 1'b1;
  end

  assign bank_req_rdy = gnt_vec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c2a_lkp_vld    <= 1'b0;
      c2a_lkp_info   <= '0;
      c2a_lkp_req_id <= '0;
      ptr            <= '0;
    end else if (gnt) begin
      c2a_lkp_vld    <= 1'b1;
      c2a_lkp_info   <= bank_req_info[gnt_idx*info_length +: info_length];
      c2a_lkp_req_id <= {bank_req_id[gnt_idx*lid_w +: lid_w], gnt_idx};
      ptr            <= gnt_idx + bw'(1);
    end else if (a2c_lkp_rdy) begin
      c2a_lkp_vld    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_rsp_vld  <= '0;
      bank_rsp_id   <= '0;
      bank_rsp_rslt <= '0;
    end else begin
      bank_rsp_vld <= rsp_vec;
      if (a2c_lkp_rsp_vld) begin
        bank_rsp_id   <= a2c_lkp_rsp_id[req_width-1:bw];
        bank_rsp_rslt <= a2c_lkp_rslt;
      end
    end
  end

endmodule
